// File: rtl/timersoc_switch_scanner_pkg.sv
// timersoc_switch_scanner_pkg
// Shared definitions for the TimerSoC switch scanner: CPU register offsets,
// register bit positions, the poll FSM state encoding and the edge event
// record that is stored in the event FIFO.
package timersoc_switch_scanner_pkg;

  // CPU slave register offsets
  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_EVENT   = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;
  localparam logic [1:0] REG_CLEAR   = 2'd3;

  // STATUS fields
  localparam int LEVEL_LSB = 0;
  localparam int COUNT_LSB = 8;
  localparam int OVF_BIT   = 16;

  // EVENT fields
  localparam int VALID_BIT = 31;
  localparam int RISE_LSB  = 2;
  localparam int FALL_LSB  = 0;

  // CONTROL fields
  localparam int EN_BIT    = 0;
  localparam int IRQEN_BIT = 1;

  // Poll sequencer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_UPDATE  = 2'd3
  } scan_state_e;

  // One queued edge event: which switches rose and which fell in one poll
  typedef struct packed {
    logic [1:0] rise;
    logic [1:0] fall;
  } sw_event_t;

endpackage

// File: rtl/timersoc_switch_scanner_evt_fifo.sv
// switch_evt_fifo
// Small synchronous FIFO holding switch edge events.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   push_i, wdata_i     write request and data (ignored when full unless
//                       a pop happens in the same cycle)
//   pop_i               read request (ignored when empty)
//   rdata_o             head entry (valid when empty_o = 0)
//   full_o, empty_o     occupancy flags
//   count_o             number of stored entries
module switch_evt_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Storage is not reset: the pointers and count define which entries are
  // live, so stale contents after reset are never observable.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a
  // simultaneous push.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/timersoc_switch_scanner.sv
// timersoc_switch_scanner
// Autonomous poller for the 2-bit switch PIO. Periodically reads the PIO
// data register as an Avalon-MM master, debounces each switch, queues edge
// events and exposes level/events/config to the CPU through an Avalon-MM
// slave with a level interrupt.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   m_address, m_read    PIO master address (always 0) and read strobe
//   m_readdata           PIO read data, valid the cycle after m_read
//   s_address, s_read,   CPU slave register select / strobes / write data
//   s_write, s_writedata
//   s_readdata           CPU read data, registered (1-cycle latency)
//   irq                  level interrupt: irq_en & (events pending | overflow)
module timersoc_switch_scanner
  import timersoc_switch_scanner_pkg::*;
#(
  parameter int POLL_DIV   = 50000,
  parameter int DEBOUNCE_N = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);

  localparam int              TIMER_W    = $clog2(POLL_DIV);
  localparam int              CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(POLL_DIV - 1);
  localparam logic [3:0]      DB_TARGET  = 4'(DEBOUNCE_N);

  // ---------------------------------------------------------------------
  // Poll sequencer
  // ---------------------------------------------------------------------
  scan_state_e        state_q;
  logic [TIMER_W-1:0] timer_q;
  logic               m_read_q;
  logic [1:0]         sample_q;
  logic [1:0]         ctrl_q, ctrl_d;

  // The timer only advances in IDLE, which makes the poll period
  // POLL_DIV + 3 cycles. Once READ is entered the sequence always runs to
  // UPDATE regardless of the enable bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      m_read_q <= 1'b0;
      sample_q <= 2'b00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          m_read_q <= 1'b0;
          if (ctrl_q[EN_BIT]) begin
            if (timer_q == TIMER_LAST) begin
              timer_q  <= '0;
              state_q  <= ST_READ;
              m_read_q <= 1'b1;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end else begin
            timer_q <= '0;
          end
        end
        ST_READ: begin
          m_read_q <= 1'b0;
          state_q  <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          sample_q <= m_readdata[1:0];
          state_q  <= ST_UPDATE;
        end
        ST_UPDATE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          m_read_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_read    = m_read_q;
  assign m_address = 2'b00;

  // ---------------------------------------------------------------------
  // Per-bit debounce
  // ---------------------------------------------------------------------
  logic [1:0] level_q, level_d;
  logic [1:0] toggle;
  logic       in_update;

  assign in_update = (state_q == ST_UPDATE);

  for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cnt_inc;
    logic       differs;

    assign cnt_inc    = cnt_q + 4'd1;
    assign differs    = (sample_q[gi] != level_q[gi]);
    assign toggle[gi] = in_update & differs & (cnt_inc == DB_TARGET);

    always_comb begin
      cnt_d = cnt_q;
      if (in_update) begin
        if (!differs || toggle[gi]) cnt_d = 4'd0;
        else                        cnt_d = cnt_inc;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= 4'd0;
      else          cnt_q <= cnt_d;
    end
  end

  assign level_d = level_q ^ toggle;

  // ---------------------------------------------------------------------
  // Edge events and FIFO
  // ---------------------------------------------------------------------
  sw_event_t        evt_new;
  sw_event_t        evt_head;
  logic [3:0]       fifo_rdata;
  logic             evt_push;
  logic             pop_req;
  logic             pop_fire;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // toggle is only non-zero in UPDATE, so a push can only occur there; two
  // bits toggling together share a single event.
  assign evt_new.rise = toggle & ~level_q;
  assign evt_new.fall = toggle & level_q;
  assign evt_push     = |toggle;

  assign pop_req  = s_read & (s_address == REG_EVENT);
  assign pop_fire = pop_req & ~fifo_empty;
  assign evt_head = sw_event_t'(fifo_rdata);

  switch_evt_fifo #(
    .WIDTH (4),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (evt_push),
    .wdata_i (evt_new),
    .pop_i   (pop_req),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // ---------------------------------------------------------------------
  // Overflow, control and CPU read path
  // ---------------------------------------------------------------------
  logic        ovf_q, ovf_d;
  logic        ovf_set, ovf_clr;
  logic [31:0] rdata_q, rdata_d;

  // A push into a full FIFO is dropped unless a pop frees a slot the same
  // cycle. A new overflow wins over a simultaneous CLEAR.
  assign ovf_set = evt_push & fifo_full & ~pop_fire;
  assign ovf_clr = s_write & (s_address == REG_CLEAR) & s_writedata[0];
  assign ovf_d   = ovf_set | (ovf_q & ~ovf_clr);

  always_comb begin
    ctrl_d = ctrl_q;
    if (s_write && (s_address == REG_CONTROL)) begin
      ctrl_d[EN_BIT]    = s_writedata[EN_BIT];
      ctrl_d[IRQEN_BIT] = s_writedata[IRQEN_BIT];
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (s_read) begin
      rdata_d = 32'd0;
      case (s_address)
        REG_STATUS: begin
          rdata_d[LEVEL_LSB +: 2] = level_q;
          rdata_d[COUNT_LSB +: 3] = 3'(fifo_count);
          rdata_d[OVF_BIT]        = ovf_q;
        end
        REG_EVENT: begin
          if (!fifo_empty) begin
            rdata_d[VALID_BIT]     = 1'b1;
            rdata_d[RISE_LSB +: 2] = evt_head.rise;
            rdata_d[FALL_LSB +: 2] = evt_head.fall;
          end
        end
        REG_CONTROL: begin
          rdata_d[EN_BIT]    = ctrl_q[EN_BIT];
          rdata_d[IRQEN_BIT] = ctrl_q[IRQEN_BIT];
        end
        default: rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= 2'b00;
      ctrl_q  <= 2'b00;
      ovf_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      level_q <= level_d;
      ctrl_q  <= ctrl_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
    end
  end

  assign s_readdata = rdata_q;
  assign irq        = ctrl_q[IRQEN_BIT] & (~fifo_empty | ovf_q);

  // Only the two switch bits of the PIO word and the low write-data bits
  // carry meaning here.
  logic unused_bits;
  assign unused_bits = ^{m_readdata[31:2], s_writedata[31:2]};

endmodule

// File: tb/tb_timersoc_switch_scanner.sv
module tb_timersoc_switch_scanner;
  import timersoc_switch_scanner_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  m_address;
  logic        m_read;
  logic [31:0] m_readdata;
  logic [1:0]  s_address;
  logic        s_read;
  logic        s_write;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic        irq;

  logic [1:0]  in_port;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          mread_cyc[$];

  always #5 clk = ~clk;

  timersoc_switch_scanner #(
    .POLL_DIV   (8),
    .DEBOUNCE_N (3),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .m_address   (m_address),
    .m_read      (m_read),
    .m_readdata  (m_readdata),
    .s_address   (s_address),
    .s_read      (s_read),
    .s_write     (s_write),
    .s_writedata (s_writedata),
    .s_readdata  (s_readdata),
    .irq         (irq)
  );

  // PIO model: registered readdata, valid the cycle after m_read
  always @(posedge clk) begin
    if (m_read) m_readdata <= {30'd0, in_port};
  end

  // Cycle counter and m_read timestamp log
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (m_read === 1'b1) mread_cyc.push_back(cyc);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cpu_write(input logic [1:0] addr, input logic [31:0] data);
    s_address   = addr;
    s_writedata = data;
    s_write     = 1'b1;
    tick(1);
    s_write     = 1'b0;
    s_writedata = 32'd0;
  endtask

  task automatic cpu_read(input logic [1:0] addr, output logic [31:0] data);
    s_address = addr;
    s_read    = 1'b1;
    tick(1);
    s_read    = 1'b0;
    data      = s_readdata;
  endtask

  task automatic read_check(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    cpu_read(addr, d);
    check_eq(tag, d, exp);
  endtask

  // Wait for the next m_read (bounded), then for CAPTURE and UPDATE to finish.
  task automatic wait_mread();
    int n = 0;
    while (m_read !== 1'b1 && n < 30) begin
      tick(1);
      n++;
    end
    if (m_read !== 1'b1) check_eq("poll_timeout", {31'd0, m_read}, 32'd1);
  endtask

  task automatic wait_poll();
    wait_mread();
    tick(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [1:0] alt [6];
    logic [31:0] pops [4];

    reset_n     = 1'b0;
    s_address   = 2'd0;
    s_read      = 1'b0;
    s_write     = 1'b0;
    s_writedata = 32'd0;
    in_port     = 2'b00;
    m_readdata  = 32'd0;
    tick(3);
    reset_n = 1'b1;
    tick(1);

    // Reset state
    check_eq("rst_s_readdata", s_readdata, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    check_eq("rst_m_read", {31'd0, m_read}, 32'd0);
    check_eq("rst_m_address", {30'd0, m_address}, 32'd0);
    read_check("rst_status", REG_STATUS, 32'd0);
    read_check("rst_event", REG_EVENT, 32'd0);
    read_check("rst_control", REG_CONTROL, 32'd0);
    tick(30);
    check_eq("no_poll_disabled", 32'(mread_cyc.size()), 32'd0);

    // Poll timing
    cpu_write(REG_CONTROL, 32'd1);
    w = cyc;
    repeat (3) wait_poll();
    check_eq("poll_count", 32'(mread_cyc.size()), 32'd3);
    if (mread_cyc.size() >= 3) begin
      check_eq("first_poll_delay", 32'(mread_cyc[0] - w), 32'd9);
      check_eq("poll_period_1", 32'(mread_cyc[1] - mread_cyc[0]), 32'd11);
      check_eq("poll_period_2", 32'(mread_cyc[2] - mread_cyc[1]), 32'd11);
    end
    read_check("control_en", REG_CONTROL, 32'd1);

    // Debounce of bit0 rising, needs 3 consecutive samples
    in_port = 2'b01;
    wait_poll();
    wait_poll();
    read_check("db_after_2", REG_STATUS, 32'h0000_0000);
    wait_poll();
    read_check("db_after_3", REG_STATUS, 32'h0000_0101);
    check_eq("irq_disabled", {31'd0, irq}, 32'd0);
    cpu_write(REG_CONTROL, 32'd3);
    check_eq("irq_pending", {31'd0, irq}, 32'd1);
    read_check("event_rise0", REG_EVENT, 32'h8000_0004);
    check_eq("irq_after_pop", {31'd0, irq}, 32'd0);
    read_check("event_empty", REG_EVENT, 32'h0000_0000);

    // Alternating samples never reach the debounce threshold
    alt = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
    for (int i = 0; i < 6; i++) begin
      in_port = alt[i];
      wait_poll();
    end
    read_check("alt_status", REG_STATUS, 32'h0000_0001);
    read_check("alt_no_event", REG_EVENT, 32'h0000_0000);

    // Five debounced toggles without popping: fifth event overflows
    for (int t = 0; t < 5; t++) begin
      in_port = (t % 2 == 0) ? 2'b00 : 2'b01;
      repeat (3) wait_poll();
    end
    check_eq("ovf_irq", {31'd0, irq}, 32'd1);
    cpu_write(REG_CONTROL, 32'd2);
    read_check("ovf_status", REG_STATUS, 32'h0001_0400);
    read_check("control_irqen", REG_CONTROL, 32'd2);
    cpu_write(REG_CLEAR, 32'd1);
    read_check("clear_status", REG_STATUS, 32'h0000_0400);
    read_check("clear_reads_0", REG_CLEAR, 32'd0);
    check_eq("irq_count_only", {31'd0, irq}, 32'd1);
    pops = '{32'h8000_0001, 32'h8000_0004, 32'h8000_0001, 32'h8000_0004};
    for (int i = 0; i < 4; i++) begin
      read_check($sformatf("pop_%0d", i), REG_EVENT, pops[i]);
    end
    read_check("drained_status", REG_STATUS, 32'h0000_0000);
    check_eq("drained_irq", {31'd0, irq}, 32'd0);

    // Both bits rising in one poll give one event
    in_port = 2'b11;
    cpu_write(REG_CONTROL, 32'd3);
    repeat (3) wait_poll();
    read_check("both_status", REG_STATUS, 32'h0000_0103);
    read_check("both_event", REG_EVENT, 32'h8000_000C);
    read_check("both_single", REG_EVENT, 32'h0000_0000);

    // Leave a pending event, then reset during CAPTURE
    in_port = 2'b00;
    repeat (3) wait_poll();
    read_check("fall_status", REG_STATUS, 32'h0000_0100);
    check_eq("fall_irq", {31'd0, irq}, 32'd1);
    wait_mread();
    tick(1);
    reset_n = 1'b0;
    #1;
    check_eq("arst_m_read", {31'd0, m_read}, 32'd0);
    check_eq("arst_s_readdata", s_readdata, 32'd0);
    check_eq("arst_irq", {31'd0, irq}, 32'd0);
    check_eq("arst_m_address", {30'd0, m_address}, 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    read_check("arst_status", REG_STATUS, 32'd0);
    read_check("arst_event", REG_EVENT, 32'd0);
    read_check("arst_control", REG_CONTROL, 32'd0);
    w = mread_cyc.size();
    tick(30);
    check_eq("arst_no_poll", 32'(mread_cyc.size() - w), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
